poly_voice_bank: RTL and testbench

Polyphonic successor to the single-voice oscillator. It takes note events from the MIDI processor, allocates them across `NUM_VOICES` independent oscillators, and keeps a per-voice phase for each. On every audio sample tick it mixes the active voices sequentially into one signed sample for the I2S transmitter.

---
 rtl/poly_voice_bank.sv | 187 ++++++++++++++++++
 tb/tb_poly_voice_bank.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/poly_voice_bank.sv
// Polyphonic oscillator bank: allocates note events across NUM_VOICES phase
// accumulators and mixes the active voices sequentially on each sample tick.
module poly_voice_bank #(
  parameter int NUM_VOICES  = 4,
  parameter int AUDIO_WIDTH = 24,
  parameter int RATE_WIDTH  = 24,
  parameter int PHASE_WIDTH = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          evt_valid_in,
  output logic                          evt_ready_out,
  input  logic                          evt_on_in,
  input  logic [6:0]                    evt_note_in,
  input  logic [RATE_WIDTH-1:0]         evt_rate_in,
  input  logic [1:0]                    wave_sel_in,
  input  logic                          sample_tick_in,
  output logic signed [AUDIO_WIDTH-1:0] sample_out,
  output logic                          sample_valid_out,
  output logic [NUM_VOICES-1:0]         active_voices_out,
  output logic                          overrun_out
);

  localparam int SHIFT = $clog2(NUM_VOICES);
  localparam int IDX_W = (NUM_VOICES > 1) ? SHIFT : 1;
  localparam int ACC_W = AUDIO_WIDTH + SHIFT;
  localparam logic signed [AUDIO_WIDTH-1:0] POS_MAX = {1'b0, {(AUDIO_WIDTH-1){1'b1}}};
  localparam logic signed [AUDIO_WIDTH-1:0] NEG_MAX = {1'b1, {(AUDIO_WIDTH-2){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_MIX} state_t;

  logic                   r_active [NUM_VOICES];
  logic [6:0]             r_note   [NUM_VOICES];
  logic [RATE_WIDTH-1:0]  r_rate   [NUM_VOICES];
  logic [RATE_WIDTH-1:0]  r_cnt    [NUM_VOICES];
  logic [PHASE_WIDTH-1:0] r_phase  [NUM_VOICES];
  logic [IDX_W-1:0]       r_steal_ptr;
  logic                   r_ready;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic signed [ACC_W-1:0] r_acc;

  logic                  w_accept;
  logic                  w_match_found;
  logic [IDX_W-1:0]      w_match_idx;
  logic                  w_free_found;
  logic [IDX_W-1:0]      w_free_idx;
  logic [IDX_W-1:0]      w_tgt_idx;
  logic [NUM_VOICES-1:0] w_load;
  logic [NUM_VOICES-1:0] w_off;

  assign w_accept      = evt_valid_in && r_ready;
  assign evt_ready_out = r_ready;

  // Descending scans so the lowest matching / free index wins.
  always_comb begin
    w_match_found = 1'b0;
    w_match_idx   = '0;
    w_free_found  = 1'b0;
    w_free_idx    = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (r_active[i] && (r_note[i] == evt_note_in)) begin
        w_match_found = 1'b1;
        w_match_idx   = IDX_W'(i);
      end
      if (!r_active[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  assign w_tgt_idx = w_match_found ? w_match_idx :
                     w_free_found  ? w_free_idx  : r_steal_ptr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      assign w_load[gi] = w_accept && evt_on_in && (w_tgt_idx == IDX_W'(gi));
      assign w_off[gi]  = w_accept && !evt_on_in && w_match_found &&
                          (w_match_idx == IDX_W'(gi));
      assign active_voices_out[gi] = r_active[gi];

      // An accepted event takes precedence over a same-cycle counter wrap.
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          r_active[gi] <= 1'b0;
          r_note[gi]   <= '0;
          r_rate[gi]   <= '0;
          r_cnt[gi]    <= '0;
          r_phase[gi]  <= '0;
        end else if (w_load[gi]) begin
          r_active[gi] <= 1'b1;
          r_note[gi]   <= evt_note_in;
          r_rate[gi]   <= evt_rate_in;
          r_cnt[gi]    <= '0;
          r_phase[gi]  <= '0;
        end else if (w_off[gi]) begin
          r_active[gi] <= 1'b0;
        end else if (r_active[gi] && (r_rate[gi] != '0)) begin
          if (r_cnt[gi] == r_rate[gi] - RATE_WIDTH'(1)) begin
            r_cnt[gi]   <= '0;
            r_phase[gi] <= r_phase[gi] + PHASE_WIDTH'(1);
          end else begin
            r_cnt[gi] <= r_cnt[gi] + RATE_WIDTH'(1);
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_ready     <= 1'b0;
      r_steal_ptr <= '0;
    end else begin
      r_ready <= 1'b1;
      if (w_accept && evt_on_in && !w_match_found && !w_free_found) begin
        r_steal_ptr <= r_steal_ptr + IDX_W'(1);
      end
    end
  end

  logic                          w_cur_active;
  logic [PHASE_WIDTH-1:0]        w_cur_phase;
  logic signed [AUDIO_WIDTH-1:0] w_voice_val;
  logic signed [ACC_W-1:0]       w_voice_ext;
  logic signed [ACC_W-1:0]       w_sum;

  assign w_cur_active = r_active[r_idx];
  assign w_cur_phase  = r_phase[r_idx];

  always_comb begin
    w_voice_val = '0;
    if (w_cur_active) begin
      case (wave_sel_in)
        2'b00:   w_voice_val = w_cur_phase[PHASE_WIDTH-1] ? NEG_MAX : POS_MAX;
        2'b01:   w_voice_val = {~w_cur_phase[PHASE_WIDTH-1], w_cur_phase[PHASE_WIDTH-2:0],
                                {(AUDIO_WIDTH-PHASE_WIDTH){1'b0}}};
        default: w_voice_val = '0;
      endcase
    end
  end

  assign w_voice_ext = ACC_W'(w_voice_val);
  assign w_sum       = r_acc + w_voice_ext;

  // The last voice is folded straight into the output so the result lands
  // NUM_VOICES+1 cycles after the tick.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state          <= S_IDLE;
      r_idx            <= '0;
      r_acc            <= '0;
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
      overrun_out      <= 1'b0;
    end else begin
      sample_valid_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sample_tick_in) begin
            r_state <= S_MIX;
            r_idx   <= '0;
            r_acc   <= '0;
          end
        end
        S_MIX: begin
          if (sample_tick_in) begin
            overrun_out <= 1'b1;
          end
          if (r_idx == IDX_W'(NUM_VOICES - 1)) begin
            sample_out       <= w_sum[ACC_W-1:SHIFT];
            sample_valid_out <= 1'b1;
            r_state          <= S_IDLE;
          end else begin
            r_acc <= w_sum;
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_voice_bank.sv
// Directed bench for poly_voice_bank: mixed samples are checked by a
// scoreboard monitor; allocation state is checked directly after each event.
module tb_poly_voice_bank;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        evt_valid_in = 1'b0;
  logic        evt_ready_out;
  logic        evt_on_in = 1'b0;
  logic [6:0]  evt_note_in = '0;
  logic [23:0] evt_rate_in = '0;
  logic [1:0]  wave_sel_in = 2'b00;
  logic        sample_tick_in = 1'b0;
  logic [23:0] sample_out;
  logic        sample_valid_out;
  logic [3:0]  active_voices_out;
  logic        overrun_out;

  poly_voice_bank dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .evt_valid_in      (evt_valid_in),
    .evt_ready_out     (evt_ready_out),
    .evt_on_in         (evt_on_in),
    .evt_note_in       (evt_note_in),
    .evt_rate_in       (evt_rate_in),
    .wave_sel_in       (wave_sel_in),
    .sample_tick_in    (sample_tick_in),
    .sample_out        (sample_out),
    .sample_valid_out  (sample_valid_out),
    .active_voices_out (active_voices_out),
    .overrun_out       (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] val;
    int          due;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec   = 0;
  int   n_miss  = 0;
  int   n_valid = 0;

  // Scoreboard monitor: every output strobe must match the oldest expectation.
  always @(negedge clk_in) begin
    if (rst_n_in && sample_valid_out) begin
      n_valid++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_valid got sample=%06h at cycle %0d, required no strobe",
                 sample_out, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (sample_out !== e.val || cyc != e.due) begin
          n_miss++;
          $display("FAIL sample_%0d got %06h at cycle %0d, required %06h at cycle %0d",
                   e.tag, sample_out, cyc, e.val, e.due);
        end else begin
          $display("sample_%0d ok: %06h at cycle %0d", e.tag, sample_out, cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s got %0h required %0h", name, got, want);
    end else begin
      $display("%s ok: %0h", name, got);
    end
  endtask

  task automatic send_evt(input logic on, input logic [6:0] note, input logic [23:0] rate);
    int k;
    @(posedge clk_in); #1;
    evt_valid_in = 1'b1;
    evt_on_in    = on;
    evt_note_in  = note;
    evt_rate_in  = rate;
    k = 0;
    while (!evt_ready_out && k < 10) begin
      @(posedge clk_in); #1;
      k++;
    end
    if (k == 10) chk("evt_ready_timeout", 32'(evt_ready_out), 32'd1);
    @(posedge clk_in); #1;
    evt_valid_in = 1'b0;
  endtask

  task automatic do_tick(input bit expect_it, input logic [23:0] v, input int tag);
    @(posedge clk_in); #1;
    sample_tick_in = 1'b1;
    if (expect_it) exp_q.push_back('{v, cyc + 5, tag});
    @(posedge clk_in); #1;
    sample_tick_in = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk_in);
    @(posedge clk_in); #1;
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;

    // 1. reset
    repeat (3) @(negedge clk_in);
    chk("rst_sample", 32'(sample_out), 32'd0);
    chk("rst_valid", 32'(sample_valid_out), 32'd0);
    chk("rst_active", 32'(active_voices_out), 32'd0);
    chk("rst_overrun", 32'(overrun_out), 32'd0);
    chk("rst_ready", 32'(evt_ready_out), 32'd0);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    chk("ready_after_release", 32'(evt_ready_out), 32'd1);
    do_tick(1, 24'h000000, 1);
    drain();

    // 2. single square voice
    wave_sel_in = 2'b00;
    send_evt(1'b1, 7'd60, 24'd4);
    chk("v60_active", 32'(active_voices_out), 32'h1);
    do_tick(1, 24'h1FFFFF, 2);
    drain();
    repeat (600) @(posedge clk_in);
    do_tick(1, 24'hE00000, 3);
    drain();

    // 3. fill and steal
    send_evt(1'b1, 7'd60, 24'd4);
    send_evt(1'b1, 7'd61, 24'd4);
    send_evt(1'b1, 7'd62, 24'd4);
    send_evt(1'b1, 7'd63, 24'd4);
    chk("full_bitmap", 32'(active_voices_out), 32'hF);
    chk("steal_ptr_before", 32'(dut.r_steal_ptr), 32'd0);
    send_evt(1'b1, 7'd64, 24'd4);
    chk("steal_bitmap", 32'(active_voices_out), 32'hF);
    chk("voice0_note", 32'(dut.r_note[0]), 32'd64);
    chk("voice3_note", 32'(dut.r_note[3]), 32'd63);
    chk("steal_ptr", 32'(dut.r_steal_ptr), 32'd1);

    // 4. note-off
    send_evt(1'b0, 7'd61, 24'd0);
    chk("off61_bitmap", 32'(active_voices_out), 32'hD);
    send_evt(1'b0, 7'd99, 24'd0);
    chk("off99_bitmap", 32'(active_voices_out), 32'hD);

    // 5. retrigger
    send_evt(1'b1, 7'd62, 24'd8);
    chk("retrig_bitmap", 32'(active_voices_out), 32'hD);
    chk("retrig_rate", 32'(dut.r_rate[2]), 32'd8);
    chk("retrig_phase", 32'(dut.r_phase[2]), 32'd0);
    chk("retrig_note", 32'(dut.r_note[2]), 32'd62);
    send_evt(1'b1, 7'd70, 24'd4);
    chk("free_claim_bitmap", 32'(active_voices_out), 32'hF);
    chk("free_claim_note", 32'(dut.r_note[1]), 32'd70);
    chk("free_claim_ptr", 32'(dut.r_steal_ptr), 32'd1);
    wave_sel_in = 2'b10;
    do_tick(1, 24'h000000, 4);
    drain();

    // reset in the middle of a mix pass: no strobe may follow
    snap = n_valid;
    do_tick(0, 24'h0, 0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    repeat (12) @(posedge clk_in);
    #1;
    chk("midmix_reset_no_valid", 32'(n_valid - snap), 32'd0);
    chk("midmix_reset_active", 32'(active_voices_out), 32'd0);
    chk("midmix_reset_overrun", 32'(overrun_out), 32'd0);

    // 6. saw, frozen phase, overrun
    wave_sel_in = 2'b01;
    send_evt(1'b1, 7'd70, 24'd0);
    snap = n_valid;
    @(posedge clk_in); #1;
    sample_tick_in = 1'b1;
    exp_q.push_back('{24'hE00000, cyc + 5, 6});
    @(posedge clk_in); #1;
    sample_tick_in = 1'b0;
    @(posedge clk_in); #1;
    sample_tick_in = 1'b1;
    @(posedge clk_in); #1;
    sample_tick_in = 1'b0;
    repeat (15) @(posedge clk_in);
    #1;
    chk("overrun_set", 32'(overrun_out), 32'd1);
    chk("single_valid", 32'(n_valid - snap), 32'd1);
    drain();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
